// File: rtl/axis_downsizer.sv
// -----------------------------------------------------------------------------
// axis_downsizer
//   AXI4-Stream wide-to-narrow width converter. Each accepted wide beat of
//   DATA_RATIO lanes is replayed as narrow beats, least-significant lane first.
//   One wide holding register; a new wide beat is accepted in the same cycle
//   the last narrow lane of the current one leaves, so the narrow stream has
//   no bubbles while the sink stays ready.
//
//   Ports
//     aclk, aresetn               clock, asynchronous active-low reset
//     s_axis_tdata/tkeep/tlast    wide beat; tkeep only matters on tlast
//     s_axis_tvalid/tready        wide handshake (tready is combinational)
//     m_axis_tdata/tlast          narrow lane, driven from flops only
//     m_axis_tvalid/tready        narrow handshake
// -----------------------------------------------------------------------------
module axis_downsizer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATA_RATIO   = 8,
    parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
    parameter int M_DATA_WIDTH = DATA_WIDTH
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    localparam int IDX_W = (DATA_RATIO > 1) ? $clog2(DATA_RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(DATA_RATIO - 1);

    if (DATA_RATIO < 2) begin : g_bad_ratio
        $error("axis_downsizer: DATA_RATIO must be >= 2");
    end

    logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] buffer;
    logic [IDX_W-1:0]                      idx;
    logic [IDX_W-1:0]                      nlanes;
    logic                                  busy;
    logic                                  last_r;

    logic             m_fire;
    logic             last_fire;
    logic             capture;
    logic [IDX_W-1:0] keep_hi;

    // Highest set keep bit. An all-zero keep resolves to lane 0 so a tlast
    // beat always produces at least one narrow beat carrying tlast.
    always_comb begin
        keep_hi = '0;
        for (int k = 0; k < DATA_RATIO; k++) begin
            if (s_axis_tkeep[k]) keep_hi = k[IDX_W-1:0];
        end
    end

    // idx is compared against nlanes rather than relying on rollover, so a
    // non-power-of-2 ratio never indexes past the last lane.
    assign m_fire        = m_axis_tvalid & m_axis_tready;
    assign last_fire     = m_fire & (idx == nlanes);
    assign s_axis_tready = aresetn & (~busy | last_fire);
    assign capture       = s_axis_tvalid & s_axis_tready;

    assign m_axis_tvalid = busy;
    assign m_axis_tdata  = buffer[idx];
    assign m_axis_tlast  = last_r & (idx == nlanes);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy   <= 1'b0;
            idx    <= '0;
            nlanes <= LAST_LANE;
            last_r <= 1'b0;
            buffer <= '0;
        end else begin
            // Capture takes priority over retiring the final lane: the reload
            // in that same cycle is what keeps the narrow stream gapless.
            if (capture) begin
                buffer <= s_axis_tdata;
                last_r <= s_axis_tlast;
                idx    <= '0;
                busy   <= 1'b1;
                nlanes <= s_axis_tlast ? keep_hi : LAST_LANE;
            end else if (last_fire) begin
                busy <= 1'b0;
            end else if (m_fire) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- AXI4-Stream width converter, wide to narrow: one S_DATA_WIDTH input beat becomes DATA_RATIO narrow output beats.
- Lane order is least-significant lane first.
- Companion to the existing upsizer. The pair brackets wide internal datapaths and CDC FIFOs: upsizer on the ingress side, this block on the egress side.
- Single clock domain, one wide holding register, full throughput. A new wide beat is accepted in the same cycle the last narrow lane leaves.

Parameters:
DATA_WIDTH, 8, narrow (output) lane width in bits
DATA_RATIO, 8, narrow lanes per wide beat; must be >= 2 (elaboration assertion)
S_DATA_WIDTH, DATA_RATIO*DATA_WIDTH, input data width (derived, do not override)
M_DATA_WIDTH, DATA_WIDTH, output data width (derived, do not override)

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
s_axis_tdata  input  S_DATA_WIDTH  wide beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  input  DATA_RATIO  per-lane valid; significant only when s_axis_tlast=1
s_axis_tvalid  input  1  wide beat valid
s_axis_tlast  input  1  last wide beat of packet
s_axis_tready  output  1  block can accept a wide beat
m_axis_tdata  output  M_DATA_WIDTH  narrow lane
m_axis_tvalid  output  1  narrow lane valid
m_axis_tlast  output  1  last narrow beat of packet
m_axis_tready  input  1  sink accepts narrow lane

Behaviour:
- Reset state: aresetn low asynchronously clears the following.
  - State: busy=0, idx=0, nlanes=DATA_RATIO-1, last_r=0, buffer=0.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready is forced to 0 while aresetn=0. It goes to 1 on the first cycle after deassertion.
- State: busy flag, buffer (S_DATA_WIDTH), idx (lane index, $clog2(DATA_RATIO) bits), nlanes (highest lane to emit), last_r.
- Outputs are functions of flops only:
  - m_axis_tvalid = busy.
  - m_axis_tdata = buffer lane idx.
  - m_axis_tlast = last_r & (idx == nlanes).
- m_fire = m_axis_tvalid & m_axis_tready.
- final = m_fire & (idx == nlanes).
- s_axis_tready = aresetn & (!busy | final). This is combinational and gives zero-bubble back-to-back operation.
- Capture (s_axis_tvalid & s_axis_tready), registered on the next edge:
  - buffer <= s_axis_tdata; last_r <= s_axis_tlast; idx <= 0; busy <= 1.
  - nlanes <= DATA_RATIO-1 if s_axis_tlast=0.
  - Otherwise nlanes <= index of the highest set bit of s_axis_tkeep.
- Keep handling:
  - Lanes below the highest set keep bit are emitted even if their keep bit is 0. No hole skipping.
  - s_axis_tkeep = 0 with tlast=1 is treated as lane 0 only (nlanes=0), so tlast is never lost.
- Advance: m_fire & !final -> idx <= idx+1.
- Final lane with no capture in the same cycle: final & !capture -> busy <= 0.
- Simultaneous final + capture: the capture wins. The buffer reloads, idx returns to 0 and busy stays 1.
- Latency: first narrow beat is valid 1 cycle after wide capture.
- Throughput: with m_axis_tready held high, 1 narrow beat per cycle, continuous.
- Data stability: while m_axis_tvalid=1 & m_axis_tready=0, tdata/tlast/tvalid hold (AXIS rule).
  - idx never changes without m_fire.
  - The buffer is never overwritten while busy, except at final.
- No wrap hazard: idx never exceeds nlanes <= DATA_RATIO-1.
- Non-power-of-2 DATA_RATIO is legal; idx compares against nlanes, not a rollover.
- Reset mid-operation: the buffered beat is discarded and no partial lanes are emitted afterward. The upstream beat in flight is the source's responsibility.

Test Plan:
- Single beat (DATA_WIDTH=8, DATA_RATIO=4):
  - Stimulus: tdata=0x44332211, tlast=1, tkeep=0xF; m_axis_tready=1.
  - Required: 0x11,0x22,0x33,0x44 on cycles 1-4; tlast only on 0x44.
  - Required: s_axis_tready=0 on cycles 1-3 and 1 on cycle 4.
- Back-to-back:
  - Stimulus: wide beats 0x44332211 (tlast=0) then 0x88776655 (tlast=1, keep=0xF), sink always ready.
  - Required: 8 consecutive narrow beats, no bubble; second beat captured in the same cycle 0x44 fires.
- Partial last:
  - Stimulus: tdata=0xDDCCBBAA, tlast=1, tkeep=0x3.
  - Required: exactly 0xAA, 0xBB, with tlast on 0xBB; next capture the cycle 0xBB fires.
  - Repeat with tkeep=0x0. Required: single beat 0xAA with tlast=1.
- Backpressure:
  - Stimulus: m_axis_tready toggled 1,0,0,1,0,1,1 during one beat.
  - Required: each lane held stable while not ready; lanes emitted in order 0..3, none duplicated or skipped.
  - Required: s_axis_tready stays 0 until the final lane fires.
- Reset mid-packet:
  - Stimulus: assert aresetn=0 asynchronously after lane 1 fires.
  - Required: m_axis_tvalid=0 and s_axis_tready=0 immediately.
  - Required: after release, s_axis_tready=1 next cycle and no stale lanes 2-3 emitted.
- Random soak:
  - Stimulus: random tvalid/tready/tkeep, 10k wide beats.
  - Required: a scoreboard comparing the narrow stream to the expected lane sequence sees zero mismatches and tlast count equals input tlast count.
